// File: rtl/bram_seq_reader.sv
// bram_seq_reader
//   Playback sequencer that owns the read port of the profile BRAM. It walks an
//   inclusive address range (modulo 2**ADDRDEPTH), either once or looping, and
//   streams each word over a valid/ready handshake through a 2-entry FIFO.
//
//   Ports
//     clk, rstn            : clock, asynchronous active-low reset
//     start, abort, loop   : playback control (start/loop/range latched on start)
//     start_addr/stop_addr : inclusive address range
//     ram_en/ram_addr      : BRAM read request (registered)
//     ram_do               : BRAM read data, valid the cycle after ram_en
//     m_data/m_valid/m_ready : output stream
//     busy, done           : run status / one-cycle completion pulse (one-shot only)
//
//   Flow control: a returned word sits on ram_do until it is pushed into the
//   buffer. The BRAM output register holds its value while ram_en is low, so a
//   word on ram_do is only at risk when a new read is sampled. A read is issued
//   only if, after this edge, the word that will be on ram_do can still be
//   pushed when that read lands, even with m_ready held low from then on.
//   That keeps 1 word/cycle with m_ready high and never loses a word.
module bram_seq_reader #(
  parameter int ADDRDEPTH = 12,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 loop,
  input  logic [ADDRDEPTH-1:0] start_addr,
  input  logic [ADDRDEPTH-1:0] stop_addr,
  output logic                 ram_en,
  output logic [ADDRDEPTH-1:0] ram_addr,
  input  logic [WIDTH-1:0]     ram_do,
  output logic [WIDTH-1:0]     m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [ADDRDEPTH-1:0] ONE = {{(ADDRDEPTH-1){1'b0}}, 1'b1};

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_buf0, r_buf1, w_buf0_nxt, w_buf1_nxt;
  logic [1:0]           r_cnt, w_cnt_nxt, w_cnt_pop;
  logic                 r_mvalid, w_mvalid_nxt;
  logic                 r_pend, w_pend_nxt, w_pend_q;   // unpushed word on ram_do
  logic                 r_ram_en, w_ram_en_nxt;
  logic [ADDRDEPTH-1:0] r_ram_addr, w_ram_addr_nxt;
  logic [ADDRDEPTH-1:0] r_cur, w_cur_nxt;
  logic [ADDRDEPTH-1:0] r_start, r_stop, w_start_nxt, w_stop_nxt;
  logic                 r_loop, w_loop_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_pop, w_push, w_start, w_abort, w_room, w_issue;
  logic                 w_last, w_loop_eff, w_final;
  logic [ADDRDEPTH-1:0] w_iss_addr;

  // ---------------------------------------------------------------- control
  assign w_pop      = r_mvalid & m_ready;
  assign w_push     = r_pend & ((r_cnt != 2'd2) | w_pop);
  assign w_start    = (r_state == S_IDLE) & start & ~abort;
  assign w_abort    = abort & (r_state != S_IDLE);
  assign w_cnt_nxt  = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  assign w_cnt_pop  = r_cnt - {1'b0, w_pop};
  assign w_pend_q   = r_ram_en | (r_pend & ~w_push);
  // Must be able to push next edge's ram_do word without relying on a pop.
  assign w_room     = ~(w_pend_q & (w_cnt_nxt == 2'd2));
  assign w_issue    = w_start | ((r_state == S_RUN) & ~abort & w_room);

  // On the start cycle the config comes straight from the inputs.
  assign w_iss_addr = w_start ? start_addr : r_cur;
  assign w_last     = (w_iss_addr == (w_start ? stop_addr : r_stop));
  assign w_loop_eff = w_start ? loop : r_loop;

  // Final word of a one-shot: nothing in flight, one left, and it leaves now.
  assign w_final    = (r_state == S_DRAIN) & ~r_ram_en & ~r_pend &
                      (r_cnt == 2'd1) & w_pop;

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // -------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (w_last & ~loop) ? S_DRAIN : S_RUN;
      S_RUN:   if (abort) w_state_nxt = S_IDLE;
               else if (w_issue & w_last & ~r_loop) w_state_nxt = S_DRAIN;
      S_DRAIN: if (abort | w_final) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- registered output values
  always_comb begin
    w_buf0_nxt     = r_buf0;
    w_buf1_nxt     = r_buf1;
    w_cnt_nxt_hold: begin end
    w_mvalid_nxt   = (w_cnt_nxt != 2'd0);
    w_pend_nxt     = w_pend_q;
    w_ram_en_nxt   = w_issue;
    w_ram_addr_nxt = r_ram_addr;
    w_cur_nxt      = r_cur;
    w_start_nxt    = r_start;
    w_stop_nxt     = r_stop;
    w_loop_nxt     = r_loop;
    w_busy_nxt     = r_busy;
    w_done_nxt     = w_final;

    // FIFO: shift on pop, then append into the first free slot.
    if (w_pop) w_buf0_nxt = r_buf1;
    if (w_push) begin
      if (w_cnt_pop == 2'd0) w_buf0_nxt = ram_do;
      else                   w_buf1_nxt = ram_do;
    end

    if (w_issue) begin
      w_ram_addr_nxt = w_iss_addr;
      // stop_addr reached: wrap to start (matters only when looping).
      w_cur_nxt = w_last ? (w_start ? start_addr : r_start) : (w_iss_addr + ONE);
    end

    if (w_start) begin
      w_start_nxt = start_addr;
      w_stop_nxt  = stop_addr;
      w_loop_nxt  = w_loop_eff;
      w_busy_nxt  = 1'b1;
    end

    if (w_final) w_busy_nxt = 1'b0;

    if (w_abort) begin
      w_mvalid_nxt = 1'b0;
      w_pend_nxt   = 1'b0;
      w_ram_en_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_cnt      <= '0;
      r_mvalid   <= 1'b0;
      r_pend     <= 1'b0;
      r_ram_en   <= 1'b0;
      r_ram_addr <= '0;
      r_cur      <= '0;
      r_start    <= '0;
      r_stop     <= '0;
      r_loop     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_buf0     <= w_buf0_nxt;
      r_buf1     <= w_buf1_nxt;
      r_cnt      <= w_abort ? 2'd0 : w_cnt_nxt;
      r_mvalid   <= w_mvalid_nxt;
      r_pend     <= w_pend_nxt;
      r_ram_en   <= w_ram_en_nxt;
      r_ram_addr <= w_ram_addr_nxt;
      r_cur      <= w_cur_nxt;
      r_start    <= w_start_nxt;
      r_stop     <= w_stop_nxt;
      r_loop     <= w_loop_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign ram_en   = r_ram_en;
  assign ram_addr = r_ram_addr;
  assign m_data   = r_buf0;
  assign m_valid  = r_mvalid;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_bram_seq_reader.sv
// Bench for bram_seq_reader: behavioral BRAM (word = addr + 0x100, output held
// while ram_en is low), scoreboard of expected stream words filled when a run
// is started and drained by a stream monitor on the falling edge.
module tb_bram_seq_reader;
  localparam int AD = 12;
  localparam int W  = 32;

  logic          clk = 1'b0, rstn = 1'b0;
  logic          start = 1'b0, abort = 1'b0, loop = 1'b0, m_ready = 1'b1;
  logic [AD-1:0] start_addr = '0, stop_addr = '0, ram_addr;
  logic          ram_en, m_valid, busy, done;
  logic [W-1:0]  ram_do = '0, m_data;

  int n_chk = 0, n_fail = 0, done_cnt = 0, exp_done = 0, stall = 0;
  logic [W-1:0] exp_q[$];

  bram_seq_reader #(.ADDRDEPTH(AD), .WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .loop(loop),
    .start_addr(start_addr), .stop_addr(stop_addr),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_do(ram_do),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mem_word(input logic [AD-1:0] a);
    return {{(W-AD){1'b0}}, a} + 32'h100;
  endfunction

  always @(posedge clk) if (ram_en) ram_do <= mem_word(ram_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (rstn && m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_word", 64'(m_data), 64'hDEAD);
      else chk("stream_data", 64'(m_data), 64'(exp_q.pop_front()));
    end
    if (rstn && done) done_cnt++;
    // Sustained stall: no read may be outstanding into a full buffer.
    if (rstn && m_valid && !m_ready) stall++; else stall = 0;
    if (stall >= 3) chk("bp_ram_en", 64'(ram_en), 64'd0);
  end

  task automatic push_run(input logic [AD-1:0] sa, input logic [AD-1:0] so, input int reps);
    logic [AD-1:0] d, a;
    d = so - sa;
    for (int r = 0; r < reps; r++) begin
      a = sa;
      for (int i = 0; i <= int'(d); i++) begin
        exp_q.push_back(mem_word(a));
        a = a + 1'b1;
      end
    end
  endtask

  task automatic oneshot(input logic [AD-1:0] sa, input logic [AD-1:0] so, input bit rnd);
    logic [AD-1:0] d;
    int n, cyc;
    d = so - sa;
    n = int'(d) + 1;
    push_run(sa, so, 1);
    start = 1'b1; start_addr = sa; stop_addr = so; loop = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start_addr = AD'($urandom); stop_addr = AD'($urandom); loop = 1'b1;
    chk("start_ram_en", 64'(ram_en), 64'd1);
    chk("start_ram_addr", 64'(ram_addr), 64'(sa));
    chk("start_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 400) begin
      if (rnd) m_ready = ($urandom_range(0, 99) < 40);
      @(posedge clk); #1;
      cyc++;
      if (!rnd && cyc == 1) chk("m_valid_k1", 64'(m_valid), 64'd0);
      if (!rnd && cyc == 2) chk("m_valid_k2", 64'(m_valid), 64'd1);
    end
    exp_done++;
    chk("done_seen", 64'(done), 64'd1);
    if (!rnd) chk("done_latency", 64'(cyc), 64'(n + 2));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("all_words_out", 64'(exp_q.size()), 64'd0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    loop = 1'b0;
  endtask

  initial begin
    int i;
    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("rst_ram_en", 64'(ram_en), 64'd0);
    chk("rst_ram_addr", 64'(ram_addr), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    oneshot(12'h004, 12'h007, 1'b0);   // basic
    oneshot(12'hFFE, 12'h001, 1'b0);   // address wrap
    oneshot(12'h020, 12'h02F, 1'b1);   // random backpressure
    oneshot(12'h009, 12'h009, 1'b0);   // single word

    // Loop + start-while-busy + abort
    push_run(12'h002, 12'h003, 3);
    start = 1'b1; start_addr = 12'h002; stop_addr = 12'h003; loop = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; loop = 1'b0;
    i = 0;
    while (exp_q.size() != 0 && i < 100) begin
      start = (i == 2); start_addr = 12'h050; stop_addr = 12'h060;
      @(posedge clk); #1;
      i++;
    end
    start = 1'b0;
    chk("loop_words_out", 64'(exp_q.size()), 64'd0);
    chk("loop_busy", 64'(busy), 64'd1);
    m_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_m_valid", 64'(m_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ram_en", 64'(ram_en), 64'd0);
    m_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("abort_no_done", 64'(done_cnt), 64'(exp_done));
    chk("abort_m_valid_later", 64'(m_valid), 64'd0);
    oneshot(12'h002, 12'h003, 1'b0);   // retrigger

    // start + abort together in IDLE
    start = 1'b1; abort = 1'b1; start_addr = 12'h005; stop_addr = 12'h006;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_ram_en", 64'(ram_en), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("sa_m_valid", 64'(m_valid), 64'd0);

    // Async reset mid-run
    push_run(12'h040, 12'h07F, 1);
    start = 1'b1; start_addr = 12'h040; stop_addr = 12'h07F; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("ar_ram_en", 64'(ram_en), 64'd0);
    chk("ar_ram_addr", 64'(ram_addr), 64'd0);
    chk("ar_m_data", 64'(m_data), 64'd0);
    chk("ar_m_valid", 64'(m_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_done", 64'(done), 64'd0);
    exp_q.delete();
    #20 rstn = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ram_en", 64'(ram_en), 64'd0);
    chk("post_rst_m_valid", 64'(m_valid), 64'd0);
    oneshot(12'h000, 12'h001, 1'b0);

    chk("done_count", 64'(done_cnt), 64'(exp_done));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
